// File: rtl/uart_rx_core_if.sv
// Receive-side output bundle of the UART: received byte, its strobe, the framing
// error strobe and the busy flag, as seen by the APB UART register block.
interface uart_rx_core_if;
   logic [7:0] RxData;
   logic       RxValid;
   logic       FrameErr;
   logic       Busy;

   modport master (output RxData, output RxValid, output FrameErr, output Busy);
   modport slave  (input  RxData, input  RxValid, input  FrameErr, input  Busy);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
// Delivers each correctly framed byte with a one-cycle RxValid strobe.
module uart_rx_core #(
   parameter int OVERSAMPLE = 16
) (
   input  logic            pClk,
   input  logic            pReset,
   input  logic [15:0]     BaudDiv,
   input  logic            RxD,
   uart_rx_core_if.master  rxPort
);

   localparam logic [3:0] LastSample = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rxState_t;

   rxState_t    state, nextState;
   logic        rxdMeta, rxdS;
   logic [15:0] tcnt;
   logic        active, tick, midTick, endTick;
   logic [3:0]  scnt;
   logic [1:0]  samp;
   logic        majority;
   logic [2:0]  bitIdx;
   logic [7:0]  shiftReg;
   logic        shiftEn, bitInc, loadData, setErr;
   logic [7:0]  rxDataReg;
   logic        rxValidReg, frameErrReg;

   // NOTE: every clocked process uses non-blocking (<=) assignments so all flops
   // update together and simulation order can never change the result.
   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         rxdMeta <= 1'b1;
         rxdS    <= 1'b1;
      end else begin
         rxdMeta <= RxD;
         rxdS    <= rxdMeta;
      end
   end

   assign active   = (state == START) || (state == DATA) || (state == STOP);
   assign tick     = active && (tcnt == BaudDiv);
   assign midTick  = tick && (scnt == 4'd9);
   assign endTick  = tick && (scnt == LastSample);
   assign majority = (samp[0] & samp[1]) | (samp[0] & rxdS) | (samp[1] & rxdS);

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: all combinational outputs get a default first, so no path through the
   // case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      nextState = state;
      shiftEn   = 1'b0;
      bitInc    = 1'b0;
      loadData  = 1'b0;
      setErr    = 1'b0;
      case (state)
         IDLE: begin
            if (!rxdS) nextState = START;
         end
         START: begin
            if (midTick && majority) nextState = IDLE;
            else if (endTick)        nextState = DATA;
         end
         DATA: begin
            if (midTick) shiftEn = 1'b1;
            if (endTick) begin
               if (bitIdx == 3'd7) nextState = STOP;
               else                bitInc    = 1'b1;
            end
         end
         STOP: begin
            if (midTick) begin
               if (majority) begin
                  loadData  = 1'b1;
                  nextState = IDLE;
               end else begin
                  setErr    = 1'b1;
                  nextState = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rxdS) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Bit timing restarts from zero on every state entry so each bit is measured
   // from its own edge.
   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         tcnt <= '0;
         scnt <= '0;
         samp <= '0;
      end else begin
         if (!active || tick) tcnt <= '0;
         else                 tcnt <= tcnt + 16'd1;

         if (nextState != state) scnt <= '0;
         else if (tick)          scnt <= scnt + 4'd1;

         if (tick && scnt == 4'd7) samp[0] <= rxdS;
         if (tick && scnt == 4'd8) samp[1] <= rxdS;
      end
   end

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         if (state != DATA) bitIdx <= '0;
         else if (bitInc)   bitIdx <= bitIdx + 3'd1;

         if (shiftEn) shiftReg <= {majority, shiftReg[7:1]};
      end
   end

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         rxDataReg   <= '0;
         rxValidReg  <= 1'b0;
         frameErrReg <= 1'b0;
      end else begin
         rxValidReg  <= loadData;
         frameErrReg <= setErr;
         if (loadData) rxDataReg <= shiftReg;
      end
   end

   assign rxPort.RxData   = rxDataReg;
   assign rxPort.RxValid  = rxValidReg;
   assign rxPort.FrameErr = frameErrReg;
   assign rxPort.Busy     = (state != IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end of the UART. Synchronises the asynchronous `RxD` line, recovers 8N1 frames with 16x oversampling and majority-vote sampling, and delivers each byte on `RxData` with a one-cycle `RxValid` strobe. It sits directly upstream of the APB UART register block, which captures `RxData` into its receive buffer on the strobe. Framing errors and false starts are detected and reported; no data is written on error.

## Interface
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; other values are unsupported.
- `pClk`  in  1  system clock; all state is on its rising edge.
- `pReset`  in  1  asynchronous, active-low reset.
- `BaudDiv`  in  16  tick divisor; one oversample tick every `BaudDiv+1` pClk cycles. Must be held stable while `Busy`=1.
- `RxD`  in  1  asynchronous serial input; idle high.
- `RxData`  out  8  last correctly framed byte, LSB received first.
- `RxValid`  out  1  one-cycle pulse when `RxData` updates.
- `FrameErr`  out  1  one-cycle pulse when the stop bit samples low.
- `Busy`  out  1  high in every state except IDLE.

## Operation
- Synchroniser: 2 flops, reset to 1. `rxd_s` is the second flop. All logic uses only `rxd_s`.
- Tick generator: 16-bit counter `tcnt`. `tick`=1 when `tcnt==BaudDiv`, and `tcnt` then wraps to 0. `tcnt` is held at 0 in IDLE and WAIT_IDLE. `BaudDiv=0` gives a tick every cycle.
- Sample counter `scnt` (4 bits): set to 0 on every state entry, increments on each tick, wraps 15->0.
- Sampling: on ticks where `scnt` is 7, 8 or 9 (pre-increment value), `rxd_s` is sampled. The bit value is the majority of the three samples, resolved on the `scnt==9` tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: `rxd_s==0` -> START.
  - START: on the `scnt==9` tick, majority 1 (false start) -> IDLE. Otherwise remain until the `scnt==15` tick -> DATA, with bit index 0.
  - DATA: the majority bit is shifted into the MSB of the shift register on the `scnt==9` tick (right shift, LSB first). On the `scnt==15` tick, the bit index increments. After index 7 -> STOP.
  - STOP: resolved on the `scnt==9` tick. Majority 1: load `RxData` from the shift register, pulse `RxValid`, go to IDLE. Majority 0: pulse `FrameErr`, leave `RxData` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: `rxd_s==1` -> IDLE. This blocks break conditions from generating repeated frames.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with one stop bit.
- `RxValid` and `FrameErr` are never high in the same cycle.
- Reset in any state: FSM to IDLE, all counters to 0, shift register to 0, synchroniser to 1, outputs to reset values. Any partial frame is discarded.

## Timing
- Reset values: `RxData`=0x00, `RxValid`=0, `FrameErr`=0, `Busy`=0.
- Falling edge on `RxD` to `rxd_s` low: 2 cycles. `Busy` rises 1 cycle after `rxd_s` falls.
- One bit period = 16*(`BaudDiv`+1) cycles. The `scnt==9` tick of the start bit occurs 10*(`BaudDiv`+1) cycles after START entry.
- `RxValid`/`FrameErr` are registered. They assert in the cycle after the STOP `scnt==9` tick, and `RxData` is valid in that same cycle. `Busy` falls in that same cycle.
- Frame latency, from START entry to `RxValid`: (9*16+10)*(`BaudDiv`+1) cycles, i.e. 154*(`BaudDiv`+1) cycles.
- Pulses are exactly 1 cycle wide. No handshake; the consumer must capture on the strobe.

## Test plan
- `BaudDiv`=3 (64 cycles/bit), send 0xA5 8N1 -> exactly one `RxValid` pulse, `RxData`=0xA5, `FrameErr` stays 0, `Busy` low afterwards.
- Start glitch: `RxD` low for 20 cycles at `BaudDiv`=3 -> START then back to IDLE, no pulses, `RxData` unchanged, `Busy` high for at most 42 cycles.
- Framing error: send 0x3C with stop bit low, then hold `RxD` low for 3 bit times -> one `FrameErr` pulse, `RxData` keeps its previous value, `Busy` stays high until `RxD` returns high. No further pulses.
- Back-to-back: 0x00, 0xFF, 0x81 with a single stop bit, no idle gap, `BaudDiv`=0 -> three `RxValid` pulses, data in that order.
- Noise: invert `RxD` for one tick at sample 8 of data bit 3 while sending 0x55 -> `RxData`=0x55, because the majority vote corrects the flipped sample.
- Reset mid-frame: assert `pReset` during DATA bit 4, release, then send 0x7E -> outputs at reset values during reset, no pulse for the aborted frame, then `RxData`=0x7E.
